// File: rtl/reconstruct_stage_param_if.sv
// rtl/reconstruct_stage_param_if.sv - input/output bus bundle for the wavelet synthesis stage
`timescale 1ns/1ps
interface reconstruct_stage_param_if #(
    parameter int WIDTH = 48
);
    logic                    din_valid;
    logic                    din_ready;
    logic                    din_sof;
    logic                    din_eof;
    logic signed [WIDTH-1:0] a_in;
    logic signed [WIDTH-1:0] d_in;
    logic                    dout_valid;
    logic                    dout_last;
    logic signed [WIDTH-1:0] r_even;
    logic signed [WIDTH-1:0] r_odd;

    modport master (
        output din_valid, din_sof, din_eof, a_in, d_in,
        input  din_ready, dout_valid, dout_last, r_even, r_odd
    );

    modport slave (
        input  din_valid, din_sof, din_eof, a_in, d_in,
        output din_ready, dout_valid, dout_last, r_even, r_odd
    );
endinterface

// File: rtl/reconstruct_stage_param.sv
// rtl/reconstruct_stage_param.sv - polyphase wavelet synthesis stage; RECON_SAT_EN selects saturating output
`timescale 1ns/1ps
module reconstruct_stage_param #(
    parameter int INTERNAL_WIDTH = 48,
    parameter int COEF_WIDTH     = 25,
    parameter int COEF_FRAC      = 23,
    parameter int NUM_TAPS       = 8,
    parameter logic [NUM_TAPS*COEF_WIDTH-1:0] REC_LO = '0,
    parameter logic [NUM_TAPS*COEF_WIDTH-1:0] REC_HI = '0
) (
    input logic                      clk,
    input logic                      rst,
    reconstruct_stage_param_if.slave io
);
    localparam int W    = INTERNAL_WIDTH;
    localparam int P    = NUM_TAPS / 2;
    localparam int PW   = INTERNAL_WIDTH + COEF_WIDTH;
    localparam int SW   = PW + $clog2(NUM_TAPS) + 1;
    localparam int CNTW = $clog2(NUM_TAPS) + 1;
    localparam logic signed [SW-1:0] RND = SW'(1) <<< (COEF_FRAC - 1);
`ifdef RECON_SAT_EN
    localparam logic signed [SW-1:0] SAT_MAX = (SW'(1) <<< (W - 1)) - SW'(1);
    localparam logic signed [SW-1:0] SAT_MIN = -(SW'(1) <<< (W - 1));
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH} state_t;

    state_t          state_q, state_d;
    logic [CNTW-1:0] wcnt_q, wcnt_d;
    logic [CNTW-1:0] fcnt_q, fcnt_d;
    logic [CNTW-1:0] warm_base;
    logic            warm_ok;
    logic            din_ready;
    logic            accept;
    logic            flush_tick;
    logic            sof_acc;
    logic            shift_en;
    logic            v0, last0;

    logic signed [W-1:0]  new_a, new_d;
    logic signed [W-1:0]  tap_a [P];
    logic signed [W-1:0]  tap_d [P];
    logic signed [PW-1:0] prod_lo_d [NUM_TAPS];
    logic signed [PW-1:0] prod_hi_d [NUM_TAPS];
    logic signed [PW-1:0] prod_lo_q [NUM_TAPS];
    logic signed [PW-1:0] prod_hi_q [NUM_TAPS];
    logic signed [SW-1:0] sum_even_d, sum_odd_d;
    logic signed [SW-1:0] sum_even_q, sum_odd_q;
    logic signed [W-1:0]  r_even_d, r_odd_d;
    logic signed [W-1:0]  r_even_q, r_odd_q;
    logic                 v1_q, l1_q, v2_q, l2_q, v3_q, l3_q;

    function automatic logic signed [PW-1:0] mul(input logic [COEF_WIDTH-1:0] c,
                                                 input logic signed [W-1:0] x);
        logic signed [PW-1:0] ce;
        logic signed [PW-1:0] xe;
        ce = PW'($signed(c));
        xe = PW'(x);
        return ce * xe;
    endfunction

    function automatic logic signed [W-1:0] finish(input logic signed [SW-1:0] s);
        logic signed [SW-1:0] sh;
        sh = (s + RND) >>> COEF_FRAC;
`ifdef RECON_SAT_EN
        if (sh > SAT_MAX) begin
            return W'(SAT_MAX);
        end else if (sh < SAT_MIN) begin
            return W'(SAT_MIN);
        end
        return W'(sh);
`else
        return W'(sh);
`endif
    endfunction

    assign din_ready  = (state_q != ST_FLUSH);
    assign accept     = io.din_valid && din_ready;
    assign flush_tick = (state_q == ST_FLUSH);
    assign sof_acc    = accept && io.din_sof;
    assign shift_en   = accept || flush_tick;
    // Flush ticks push zeros through the filter to drain the tail of the frame.
    assign new_a      = flush_tick ? '0 : io.a_in;
    assign new_d      = flush_tick ? '0 : io.d_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        unique case (state_q)
            ST_IDLE, ST_RUN: begin
                if (accept) begin
                    if (io.din_eof) begin
                        if (P > 1) begin
                            state_d = ST_FLUSH;
                            fcnt_d  = CNTW'(P - 1);
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_FLUSH: begin
                fcnt_d = fcnt_q - CNTW'(1);
                if (fcnt_q == CNTW'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A sof sample sees an empty history, so it counts as the first warm-up sample.
    always_comb begin
        warm_base = sof_acc ? '0 : wcnt_q;
        warm_ok   = (warm_base == CNTW'(P - 1));
        wcnt_d    = wcnt_q;
        if (accept) begin
            wcnt_d = warm_ok ? warm_base : warm_base + CNTW'(1);
        end
        v0    = (accept && warm_ok) || flush_tick;
        last0 = (flush_tick && (fcnt_q == CNTW'(1))) || (accept && io.din_eof && (P == 1));
    end

    generate
        if (P > 1) begin : g_hist
            logic signed [W-1:0] hist_a_q [P-1];
            logic signed [W-1:0] hist_d_q [P-1];

            always_comb begin
                tap_a[0] = new_a;
                tap_d[0] = new_d;
                for (int k = 1; k < P; k++) begin
                    tap_a[k] = sof_acc ? '0 : hist_a_q[k-1];
                    tap_d[k] = sof_acc ? '0 : hist_d_q[k-1];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int j = 0; j < P - 1; j++) begin
                        hist_a_q[j] <= '0;
                        hist_d_q[j] <= '0;
                    end
                end else if (shift_en) begin
                    for (int j = 0; j < P - 1; j++) begin
                        hist_a_q[j] <= tap_a[j];
                        hist_d_q[j] <= tap_d[j];
                    end
                end
            end
        end else begin : g_nohist
            always_comb begin
                tap_a[0] = new_a;
                tap_d[0] = new_d;
            end
        end
    endgenerate

    // Coefficient i feeds the even phase when i is even and the odd phase otherwise.
    always_comb begin
        for (int i = 0; i < NUM_TAPS; i++) begin
            prod_lo_d[i] = mul(REC_LO[i*COEF_WIDTH +: COEF_WIDTH], tap_a[i/2]);
            prod_hi_d[i] = mul(REC_HI[i*COEF_WIDTH +: COEF_WIDTH], tap_d[i/2]);
        end
    end

    always_comb begin
        sum_even_d = '0;
        sum_odd_d  = '0;
        for (int i = 0; i < NUM_TAPS; i++) begin
            if (i % 2 == 0) begin
                sum_even_d = sum_even_d + SW'(prod_lo_q[i]) + SW'(prod_hi_q[i]);
            end else begin
                sum_odd_d = sum_odd_d + SW'(prod_lo_q[i]) + SW'(prod_hi_q[i]);
            end
        end
    end

    always_comb begin
        r_even_d = finish(sum_even_q);
        r_odd_d  = finish(sum_odd_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                prod_lo_q[i] <= '0;
                prod_hi_q[i] <= '0;
            end
            sum_even_q <= '0;
            sum_odd_q  <= '0;
            r_even_q   <= '0;
            r_odd_q    <= '0;
            v1_q       <= 1'b0;
            l1_q       <= 1'b0;
            v2_q       <= 1'b0;
            l2_q       <= 1'b0;
            v3_q       <= 1'b0;
            l3_q       <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                prod_lo_q[i] <= prod_lo_d[i];
                prod_hi_q[i] <= prod_hi_d[i];
            end
            sum_even_q <= sum_even_d;
            sum_odd_q  <= sum_odd_d;
            r_even_q   <= r_even_d;
            r_odd_q    <= r_odd_d;
            v1_q       <= v0;
            l1_q       <= last0 && v0;
            v2_q       <= v1_q;
            l2_q       <= l1_q;
            v3_q       <= v2_q;
            l3_q       <= l2_q;
        end
    end

    assign io.din_ready  = din_ready;
    assign io.dout_valid = v3_q;
    assign io.dout_last  = l3_q;
    assign io.r_even     = r_even_q;
    assign io.r_odd      = r_odd_q;
endmodule

// File: tb/tb_reconstruct_stage_param.sv
// tb/tb_reconstruct_stage_param.sv - directed table-driven bench for reconstruct_stage_param
`timescale 1ns/1ps
module tb_reconstruct_stage_param;
    localparam int W  = 48;
    localparam int CW = 25;
    localparam logic [CW-1:0] ONE  = 25'd8388608;
    localparam logic [CW-1:0] HALF = 25'd4194304;
    localparam logic [CW-1:0] NEG1 = 25'h1800000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reconstruct_stage_param_if #(.WIDTH(W)) if2 ();
    reconstruct_stage_param_if #(.WIDTH(W)) if8 ();
    reconstruct_stage_param_if #(.WIDTH(W)) ifr ();
    reconstruct_stage_param_if #(.WIDTH(W)) ifs ();

    reconstruct_stage_param #(.NUM_TAPS(2), .REC_LO({ONE, ONE}), .REC_HI({NEG1, ONE}))
        u2 (.clk(clk), .rst(rst), .io(if2));
    reconstruct_stage_param #(.NUM_TAPS(8), .REC_LO({{(7*CW){1'b0}}, ONE}), .REC_HI('0))
        u8 (.clk(clk), .rst(rst), .io(if8));
    reconstruct_stage_param #(.NUM_TAPS(2), .REC_LO({{CW{1'b0}}, HALF}), .REC_HI('0))
        ur (.clk(clk), .rst(rst), .io(ifr));
    reconstruct_stage_param #(.NUM_TAPS(2), .REC_LO({ONE, ONE}), .REC_HI({ONE, ONE}))
        us (.clk(clk), .rst(rst), .io(ifs));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        logic   sof;
        logic   eof;
        longint a;
        longint d;
        longint ev;
        longint od;
        logic   last;
    } vec_t;

    typedef struct {
        longint a;
        longint ev;
    } rvec_t;

    typedef struct {
        logic   rst;
        logic   v;
        logic   sof;
        logic   eof;
        longint a;
        logic   rdy;
        logic   ov;
        logic   ol;
        longint oe;
    } cyc_t;

    vec_t   tv [6];
    rvec_t  rv [5];
    cyc_t   cy [29];
    longint sat_exp;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tv[0] = '{1'b1, 1'b0,  100,  20,  120,   80, 1'b0};
        tv[1] = '{1'b0, 1'b0,  -50,  30,  -20,  -80, 1'b0};
        tv[2] = '{1'b0, 1'b0,    7,   7,   14,    0, 1'b0};
        tv[3] = '{1'b0, 1'b1, 1000,  -1,  999, 1001, 1'b1};
        tv[4] = '{1'b1, 1'b1,   -3,  -4,   -7,    1, 1'b1};
        tv[5] = '{1'b0, 1'b0,    0,   0,    0,    0, 1'b0};

        rv[0] = '{3, 2};
        rv[1] = '{-3, -1};
        rv[2] = '{1, 1};
        rv[3] = '{-1, 0};
        rv[4] = '{5, 3};

        for (int c = 0; c < 29; c++) begin
            cy[c] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 0};
        end
        for (int c = 0; c < 5; c++) begin
            cy[c].v = 1'b1;
            cy[c].a = c + 1;
        end
        cy[0].sof = 1'b1;
        cy[4].eof = 1'b1;
        for (int c = 5; c < 8; c++) begin
            cy[c].v   = 1'b1;
            cy[c].a   = 99;
            cy[c].rdy = 1'b0;
        end
        cy[6].ov = 1'b1; cy[6].oe = 4;
        cy[7].ov = 1'b1; cy[7].oe = 5;
        for (int c = 8; c < 11; c++) cy[c].ov = 1'b1;
        cy[10].ol = 1'b1;
        cy[12].v = 1'b1; cy[12].a = 7;
        cy[13].v = 1'b1; cy[13].a = 8;
        cy[14].rst = 1'b1;
        for (int c = 19; c < 23; c++) begin
            cy[c].v = 1'b1;
            cy[c].a = c - 9;
        end
        cy[25].ov = 1'b1; cy[25].oe = 13;
        cy[24].v = 1'b1; cy[24].sof = 1'b1; cy[24].a = 20;

        if2.din_valid = 0; if2.din_sof = 0; if2.din_eof = 0; if2.a_in = '0; if2.d_in = '0;
        if8.din_valid = 0; if8.din_sof = 0; if8.din_eof = 0; if8.a_in = '0; if8.d_in = '0;
        ifr.din_valid = 0; ifr.din_sof = 0; ifr.din_eof = 0; ifr.a_in = '0; ifr.d_in = '0;
        ifs.din_valid = 0; ifs.din_sof = 0; ifs.din_eof = 0; ifs.a_in = '0; ifs.d_in = '0;

        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset u8 dout_valid", if8.dout_valid, 0);
        chk("reset u8 dout_last", if8.dout_last, 0);
        chk("reset u8 r_even", if8.r_even, 0);
        chk("reset u8 r_odd", if8.r_odd, 0);
        chk("reset u8 din_ready", if8.din_ready, 1);
        chk("reset u2 dout_valid", if2.dout_valid, 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if2.din_valid = 1'b1;
            if2.din_sof   = tv[i].sof;
            if2.din_eof   = tv[i].eof;
            if2.a_in      = W'(tv[i].a);
            if2.d_in      = W'(tv[i].d);
            @(negedge clk);
            if2.din_valid = 1'b0;
            if2.din_sof   = 1'b0;
            if2.din_eof   = 1'b0;
            chk($sformatf("u2 v%0d valid+1", i), if2.dout_valid, 0);
            chk($sformatf("u2 v%0d ready", i), if2.din_ready, 1);
            @(negedge clk);
            chk($sformatf("u2 v%0d valid+2", i), if2.dout_valid, 0);
            @(negedge clk);
            chk($sformatf("u2 v%0d valid", i), if2.dout_valid, 1);
            chk($sformatf("u2 v%0d r_even", i), if2.r_even, tv[i].ev);
            chk($sformatf("u2 v%0d r_odd", i), if2.r_odd, tv[i].od);
            chk($sformatf("u2 v%0d last", i), if2.dout_last, tv[i].last);
        end

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ifr.din_valid = 1'b1;
            ifr.din_sof   = (i == 0);
            ifr.a_in      = W'(rv[i].a);
            @(negedge clk);
            ifr.din_valid = 1'b0;
            ifr.din_sof   = 1'b0;
            @(negedge clk);
            @(negedge clk);
            chk($sformatf("round v%0d valid", i), ifr.dout_valid, 1);
            chk($sformatf("round v%0d r_even", i), ifr.r_even, rv[i].ev);
        end

`ifdef RECON_SAT_EN
        sat_exp = (longint'(1) <<< 47) - 1;
`else
        sat_exp = -(longint'(1) <<< 47);
`endif
        @(negedge clk);
        ifs.din_valid = 1'b1;
        ifs.din_sof   = 1'b1;
        ifs.a_in      = 48'sh4000_0000_0000;
        ifs.d_in      = 48'sh4000_0000_0000;
        @(negedge clk);
        ifs.din_valid = 1'b0;
        ifs.din_sof   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("sat valid", ifs.dout_valid, 1);
        chk("sat r_even", ifs.r_even, sat_exp);
        chk("sat r_odd", ifs.r_odd, sat_exp);

        for (int c = 0; c < 29; c++) begin
            @(negedge clk);
            chk($sformatf("u8 c%0d ready", c), if8.din_ready, cy[c].rdy);
            chk($sformatf("u8 c%0d valid", c), if8.dout_valid, cy[c].ov);
            chk($sformatf("u8 c%0d last", c), if8.dout_last, cy[c].ol);
            if (cy[c].ov) begin
                chk($sformatf("u8 c%0d r_even", c), if8.r_even, cy[c].oe);
                chk($sformatf("u8 c%0d r_odd", c), if8.r_odd, 0);
            end
            rst           = cy[c].rst;
            if8.din_valid = cy[c].v;
            if8.din_sof   = cy[c].sof;
            if8.din_eof   = cy[c].eof;
            if8.a_in      = W'(cy[c].a);
            if8.d_in      = '0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/reconstruct_stage_param.md
Name: reconstruct_stage_param

Overview:
- Generic single-level wavelet synthesis stage: consumes one approximation (a) and one detail (d) coefficient per accepted cycle; emits two reconstructed samples (even/odd phase) per input.
- Polyphase low-pass plus high-pass filtering with configurable tap count, frame start/end handling, tail flush and round-to-nearest output.
- Instantiated once per decomposition level and chained: output pair of level k is serialised upstream into the a-input of level k-1.

Parameters:
- INTERNAL_WIDTH, 48, signed data width of a, d and outputs.
- COEF_WIDTH, 25, signed coefficient width.
- COEF_FRAC, 23, fractional bits of coefficients (Q1.23).
- NUM_TAPS, 8, filter length; must be even and at least 2. P = NUM_TAPS/2 polyphase taps per phase.
- REC_LO, all zero, packed NUM_TAPS*COEF_WIDTH reconstruction low-pass coefficients; tap i occupies bits [i*COEF_WIDTH +: COEF_WIDTH].
- REC_HI, all zero, packed reconstruction high-pass coefficients, same layout as REC_LO.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset: one clock, synchronous, active-high.
- din_valid, input, 1, a_in/d_in valid.
- din_ready, input-side handshake, output, 1, stage can accept; low during flush.
- din_sof, input, 1, first sample of frame; qualified by accept.
- din_eof, input, 1, last sample of frame; qualified by accept.
- a_in, input, INTERNAL_WIDTH, approximation coefficient, signed.
- d_in, input, INTERNAL_WIDTH, detail coefficient, signed.
- dout_valid, output, 1, output pair valid.
- dout_last, output, 1, final pair of frame.
- r_even, output, INTERNAL_WIDTH, even-phase reconstructed sample.
- r_odd, output, INTERNAL_WIDTH, odd-phase reconstructed sample.

Behaviour:
- Accept: din_valid && din_ready. No output backpressure.
- Sample x[n] = (a[n], d[n]). Filter equations, k = 0..P-1:
  - r_even[n] = sum of (REC_LO[2k]·a[n-k] + REC_HI[2k]·d[n-k])
  - r_odd[n] = sum of (REC_LO[2k+1]·a[n-k] + REC_HI[2k+1]·d[n-k])
- History: P-1 deep shift registers for a and d. Shift on accept or on flush tick only.
- Pipeline, 3 cycles from accept/flush tick to dout_valid:
  - S1: 2·NUM_TAPS products, each INTERNAL_WIDTH+COEF_WIDTH bits, registered.
  - S2: adder tree, width product + clog2(NUM_TAPS) + 1, registered.
  - S3: add 2^(COEF_FRAC-1), arithmetic shift right by COEF_FRAC, take low INTERNAL_WIDTH bits (wrap), registered.
- Warm-up:
  - Counter wcnt, saturating at P-1, cleared by reset and by accepted sof.
  - An accepted sample produces dout_valid only if wcnt == P-1 before it. Suppressed samples still shift history.
  - NUM_TAPS=2: no warm-up.
- Frame start: sof accepted clears history to zero in the same cycle; the sof sample enters as the newest tap with zeros behind it, and wcnt restarts.
- FSM:
  - IDLE: din_ready=1. Goes to RUN on an accepted sample.
  - RUN: din_ready=1. Accepted eof with P>1 → FLUSH, flush counter fcnt=P-1. Accepted eof with P==1 → IDLE.
  - FLUSH: din_ready=0. Each cycle injects a zero (a, d) tick that shifts history and produces a valid output; fcnt decrements. At fcnt==1 → IDLE.
- dout_last: high with the output of the final flush tick, or of the eof sample when P==1. Travels through the pipeline with dout_valid.
- Corner cases:
  - sof and eof on the same accepted sample: clear history, then flush.
  - din_valid during FLUSH: ignored, not accepted.
  - sof with no preceding eof: frame restarts without flush.
- Reset values:
  - dout_valid, dout_last, r_even, r_odd, wcnt, fcnt, history, pipeline valids: 0.
  - FSM: IDLE; din_ready = 1 after reset.
  - Reset mid-operation drops all in-flight outputs; no dout_valid for 3 cycles after release unless new input arrives.

Optional Feature:
- RECON_SAT_EN defined: S3 saturates the shifted result to [-2^(W-1), 2^(W-1)-1], W = INTERNAL_WIDTH, instead of wrapping.
- Not defined: wraps (truncation of upper bits).
- Latency is unchanged either way.

Test Plan:
- NUM_TAPS=2, REC_LO={1.0,1.0}, REC_HI={1.0,-1.0} (1.0=8388608); a=100, d=20 with sof → 3 cycles later dout_valid=1, r_even=120, r_odd=80.
- NUM_TAPS=8, REC_LO tap0=1.0, rest 0; sof plus 5 samples a=1..5, d=0 → first 3 suppressed; outputs r_even=4, then 5, each exactly 3 cycles after its accept.
- Same config, eof on 5th sample → din_ready low 3 cycles, 3 extra outputs (r_even=0), dout_last only on the last one; din_valid held high during flush is not accepted.
- Rounding: REC_LO tap0=0.5 (4194304), a=3 → r_even=2; a=-3 → r_even=-1.
- Saturation: REC_LO={1.0,1.0}, REC_HI={1.0,1.0}, a=d=2^46 → with RECON_SAT_EN r_even=2^47-1; without it r_even=-2^47.
- Assert rst for 1 cycle while 2 outputs in flight → no dout_valid for the next 3 cycles; wcnt restarts warm-up.
